spi_master_ram_if: RTL

- Single-clock SPI master that drives the slave side of the SPI-to-RAM link. Serialises 10-bit command frames onto MOSI under SS_n.
- For read-data commands, captures the 8-bit response returned on MISO.
- Sits between the host/test logic and the SPI slave + RAM pair, in the same clk domain; there is no separate SCLK.

---
 rtl/spi_master_ram_if.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/spi_master_ram_if.sv
// ---------------------------------------------------------------------------
// spi_master_ram_if
//
// Single-clock SPI master that feeds 10-bit command frames to the slave side
// of the SPI-to-RAM link and, for read-data commands, collects the byte that
// the slave returns on MISO. Everything runs on the system clock (no SCLK).
//
// Frame layout (cmd_data): [DATA_SIZE+1:DATA_SIZE] command
//   00 write address, 01 write data, 10 read address, 11 read data
//   [DATA_SIZE-1:0] address or data payload.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   cmd_valid  host presents a frame on cmd_data
//   cmd_ready  high only while idle; accept on cmd_valid && cmd_ready
//   cmd_data   frame to send
//   SS_n       slave select, active low
//   MOSI       serial data to slave, MSB first
//   MISO       serial data from slave, MSB first
//   rd_data    last captured read byte (held until the next read completes)
//   rd_valid   one-cycle strobe marking a fresh rd_data
//   busy       high whenever a frame is in progress (any state but IDLE)
// ---------------------------------------------------------------------------
module spi_master_ram_if #(
  parameter int DATA_SIZE = 8,
  parameter int RD_WAIT   = 2,
  parameter int GAP       = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [DATA_SIZE+1:0] cmd_data,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 busy
);

  localparam int FRAME_W = DATA_SIZE + 2;

  // One shared counter serves SHIFT, WAIT, CAPTURE and STOP, so it must hold
  // the longest of those phases. The frame is always the longest phase of
  // SHIFT/CAPTURE, leaving RD_WAIT and GAP as the other candidates.
  localparam int CNT_MAX_A = (FRAME_W > RD_WAIT) ? FRAME_W : RD_WAIT;
  localparam int CNT_MAX   = (CNT_MAX_A > GAP) ? CNT_MAX_A : GAP;
  localparam int CNT_W     = $clog2(CNT_MAX);

  // Terminal compares use "length minus one" because the counter starts at
  // zero on entry to each phase.
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(DATA_SIZE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    SHIFT   = 3'd2,
    WAIT    = 3'd3,
    CAPTURE = 3'd4,
    STOP    = 3'd5
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [FRAME_W-1:0]   shreg;
  logic                 is_rd;

  // Whole controller in one registered block. The shift register is reused:
  // it empties itself while the frame goes out on MOSI (zeros shift in), so
  // by the time CAPTURE starts it is clean and collects MISO from the LSB.
  // The command type is kept separately because it has left the shift
  // register by the end of SHIFT, which is where the WAIT/STOP choice is made.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      is_rd     <= 1'b0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          SS_n      <= 1'b1;
          MOSI      <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            shreg     <= cmd_data;
            is_rd     <= &cmd_data[FRAME_W-1 -: 2];
            state     <= START;
            SS_n      <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            cnt       <= '0;
          end
        end

        // Slave sees SS_n low with MOSI idle for one cycle before bit 9.
        START: begin
          state <= SHIFT;
          MOSI  <= shreg[FRAME_W-1];
          shreg <= {shreg[FRAME_W-2:0], 1'b0};
          cnt   <= '0;
        end

        // MOSI is launched one edge ahead, so the bit on the wire while the
        // counter reads n is frame bit (FRAME_W-1-n).
        SHIFT: begin
          if (cnt == SHIFT_LAST) begin
            MOSI <= 1'b0;
            cnt  <= '0;
            if (is_rd) begin
              state <= WAIT;
            end else begin
              state <= STOP;
              SS_n  <= 1'b1;
            end
          end else begin
            MOSI  <= shreg[FRAME_W-1];
            shreg <= {shreg[FRAME_W-2:0], 1'b0};
            cnt   <= cnt + 1'b1;
          end
        end

        // Turnaround so the slave can fetch the RAM byte.
        WAIT: begin
          if (cnt == WAIT_LAST) begin
            state <= CAPTURE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // The last sample is folded straight into rd_data so the byte and its
        // strobe appear together on the cycle SS_n goes back high.
        CAPTURE: begin
          shreg <= {shreg[FRAME_W-2:0], MISO};
          if (cnt == CAP_LAST) begin
            rd_data  <= {shreg[DATA_SIZE-2:0], MISO};
            rd_valid <= 1'b1;
            state    <= STOP;
            SS_n     <= 1'b1;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Deselect time before the next frame; not ready until back in IDLE.
        STOP: begin
          if (cnt == GAP_LAST) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          SS_n      <= 1'b1;
          MOSI      <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          cnt       <= '0;
        end
      endcase
    end
  end

endmodule
